// File: rtl/id_hazard_fwd_unit_if.sv
// Bundle for the ID-stage hazard/forwarding unit: operand request, write-back paths, control outputs.
// Purely combinational grouping; no storage and no timing of its own.
// No backpressure: stall/flush outputs are the only flow control toward the pipeline.
interface id_hazard_fwd_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid_i;
  logic [ADDR_W-1:0] id_rs_addr_i;
  logic [ADDR_W-1:0] id_rt_addr_i;
  logic              id_rs_rena_i;
  logic              id_rt_rena_i;
  logic [DATA_W-1:0] rf_rs_data_i;
  logic [DATA_W-1:0] rf_rt_data_i;
  logic              ex_wena_i;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic              ex_is_load_i;
  logic [DATA_W-1:0] ex_result_i;
  logic              mem_wena_i;
  logic [ADDR_W-1:0] mem_waddr_i;
  logic [DATA_W-1:0] mem_result_i;
  logic              wb_wena_i;
  logic [ADDR_W-1:0] wb_waddr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              branch_taken_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              stall_o;
  logic              flush_o;
  logic              stall_err_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  fwd_count_o;
  logic [CNT_W-1:0]  flush_count_o;

  // Pipeline side that feeds the unit and consumes its decisions.
  modport master (
    output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rs_rena_i, id_rt_rena_i,
           rf_rs_data_i, rf_rt_data_i, ex_wena_i, ex_waddr_i, ex_is_load_i, ex_result_i,
           mem_wena_i, mem_waddr_i, mem_result_i, wb_wena_i, wb_waddr_i, wb_data_i,
           branch_taken_i,
    input  rs_data_o, rt_data_o, stall_o, flush_o, stall_err_o,
           stall_cycles_o, fwd_count_o, flush_count_o
  );

  // The hazard/forwarding unit itself.
  modport slave (
    input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rs_rena_i, id_rt_rena_i,
           rf_rs_data_i, rf_rt_data_i, ex_wena_i, ex_waddr_i, ex_is_load_i, ex_result_i,
           mem_wena_i, mem_waddr_i, mem_result_i, wb_wena_i, wb_waddr_i, wb_data_i,
           branch_taken_i,
    output rs_data_o, rt_data_o, stall_o, flush_o, stall_err_o,
           stall_cycles_o, fwd_count_o, flush_count_o
  );
endinterface

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage operand forwarding, load-use / RAW stall, branch flush and stall watchdog.
// Latency: operands, stall and flush are combinational; watchdog and counters update at clk_i.
// Backpressure: stall_o holds PC and IF/ID; a stalled taken branch does not flush until it clears.
// Optional HAZARD_PERF_EN macro: when defined, stall/forward/flush performance counters are built.
module id_hazard_fwd_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FWD_MODE  = 1,
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_hazard_fwd_unit_if.slave bus
);

  typedef enum logic {RUN, STALL} state_t;
  typedef enum logic [1:0] {SEL_RF, SEL_EX, SEL_MEM, SEL_WB} sel_t;

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  sel_t rs_sel, rt_sel;
  logic stall, flush;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  // A match needs a read-enabled, non-zero source address hitting an enabled writer.
  assign ex_rs  = bus.id_rs_rena_i && (bus.id_rs_addr_i != '0) && bus.ex_wena_i  && (bus.ex_waddr_i  == bus.id_rs_addr_i);
  assign ex_rt  = bus.id_rt_rena_i && (bus.id_rt_addr_i != '0) && bus.ex_wena_i  && (bus.ex_waddr_i  == bus.id_rt_addr_i);
  assign mem_rs = bus.id_rs_rena_i && (bus.id_rs_addr_i != '0) && bus.mem_wena_i && (bus.mem_waddr_i == bus.id_rs_addr_i);
  assign mem_rt = bus.id_rt_rena_i && (bus.id_rt_addr_i != '0) && bus.mem_wena_i && (bus.mem_waddr_i == bus.id_rt_addr_i);
  assign wb_rs  = bus.id_rs_rena_i && (bus.id_rs_addr_i != '0) && bus.wb_wena_i  && (bus.wb_waddr_i  == bus.id_rs_addr_i);
  assign wb_rt  = bus.id_rt_rena_i && (bus.id_rt_addr_i != '0) && bus.wb_wena_i  && (bus.wb_waddr_i  == bus.id_rt_addr_i);

  // Operand source select: youngest writer wins; load results are not yet available in EX.
  always_comb begin
    rs_sel = SEL_RF;
    rt_sel = SEL_RF;
    if (FWD_MODE != 0) begin
      if (ex_rs && !bus.ex_is_load_i) rs_sel = SEL_EX;
      else if (mem_rs)                rs_sel = SEL_MEM;
      else if (wb_rs)                 rs_sel = SEL_WB;
      if (ex_rt && !bus.ex_is_load_i) rt_sel = SEL_EX;
      else if (mem_rt)                rt_sel = SEL_MEM;
      else if (wb_rt)                 rt_sel = SEL_WB;
    end else begin
      if (wb_rs) rs_sel = SEL_WB;
      if (wb_rt) rt_sel = SEL_WB;
    end
  end

  // Operand data muxes driven by the selects above.
  always_comb begin
    case (rs_sel)
      SEL_EX:  bus.rs_data_o = bus.ex_result_i;
      SEL_MEM: bus.rs_data_o = bus.mem_result_i;
      SEL_WB:  bus.rs_data_o = bus.wb_data_i;
      default: bus.rs_data_o = bus.rf_rs_data_i;
    endcase
    case (rt_sel)
      SEL_EX:  bus.rt_data_o = bus.ex_result_i;
      SEL_MEM: bus.rt_data_o = bus.mem_result_i;
      SEL_WB:  bus.rt_data_o = bus.wb_data_i;
      default: bus.rt_data_o = bus.rf_rt_data_i;
    endcase
  end

  // Stall on load-use with forwarding, or on any EX/MEM RAW in legacy mode; stall beats flush.
  always_comb begin
    stall = 1'b0;
    if (FWD_MODE != 0) stall = bus.id_valid_i && bus.ex_is_load_i && (ex_rs || ex_rt);
    else               stall = bus.id_valid_i && (ex_rs || ex_rt || mem_rs || mem_rt);
    flush = bus.id_valid_i && bus.branch_taken_i && !stall;
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.stall_err_o = err_q;

  // Watchdog FSM next state: count consecutive stall cycles, saturate, latch the error.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;
    case (state_q)
      RUN:   if (stall)  state_d = STALL;
      STALL: if (!stall) state_d = RUN;
    endcase
    if (stall) run_d = (run_q == MAX_RUN) ? run_q : run_q + 1'b1;
    else       run_d = '0;
    if (stall && (run_d == MAX_RUN)) err_d = 1'b1;
  end

  // Watchdog FSM state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q, flush_cnt_q;
  logic [1:0]       fwd_inc;

  // Operands actually delivered from a bypass path this cycle (only when ID advances).
  always_comb begin
    fwd_inc = 2'd0;
    if (bus.id_valid_i && !stall)
      fwd_inc = {1'b0, rs_sel != SEL_RF} + {1'b0, rt_sel != SEL_RF};
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
      fwd_cnt_q   <= fwd_cnt_q + CNT_W'(fwd_inc);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
    end
  end

  assign bus.stall_cycles_o = stall_cnt_q;
  assign bus.fwd_count_o    = fwd_cnt_q;
  assign bus.flush_count_o  = flush_cnt_q;
`else
  assign bus.stall_cycles_o = '0;
  assign bus.fwd_count_o    = '0;
  assign bus.flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Bench for id_hazard_fwd_unit: one forwarding instance and one legacy instance with a short watchdog.
// Both see identical stimulus; expected responses are queued by the driver and checked by a monitor.
module tb_id_hazard_fwd_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          valid, rsen, rten, exw, exld, memw, wbw, br;
    bit [4:0]    rs, rt, exa, mema, wba;
    bit [31:0]   rfrs, rfrt, exr, memr, wbd;
  } stim_t;

  typedef struct {
    bit [31:0] rs, rt;
    bit        stall, flush, err;
    bit [31:0] sc, fc, flc;
  } exp_t;

  typedef struct {
    int        run;
    bit        err;
    bit [31:0] sc, fc, flc;
  } mstate_t;

  id_hazard_fwd_unit_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) b1 ();
  id_hazard_fwd_unit_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) b0 ();

  id_hazard_fwd_unit #(.DATA_W(32), .ADDR_W(5), .FWD_MODE(1), .MAX_STALL(15), .CNT_W(32))
    u1 (.clk_i(clk_i), .rst_i(rst_i), .bus(b1));
  id_hazard_fwd_unit #(.DATA_W(32), .ADDR_W(5), .FWD_MODE(0), .MAX_STALL(3), .CNT_W(32))
    u0 (.clk_i(clk_i), .rst_i(rst_i), .bus(b0));

  assign b0.id_valid_i     = b1.id_valid_i;
  assign b0.id_rs_addr_i   = b1.id_rs_addr_i;
  assign b0.id_rt_addr_i   = b1.id_rt_addr_i;
  assign b0.id_rs_rena_i   = b1.id_rs_rena_i;
  assign b0.id_rt_rena_i   = b1.id_rt_rena_i;
  assign b0.rf_rs_data_i   = b1.rf_rs_data_i;
  assign b0.rf_rt_data_i   = b1.rf_rt_data_i;
  assign b0.ex_wena_i      = b1.ex_wena_i;
  assign b0.ex_waddr_i     = b1.ex_waddr_i;
  assign b0.ex_is_load_i   = b1.ex_is_load_i;
  assign b0.ex_result_i    = b1.ex_result_i;
  assign b0.mem_wena_i     = b1.mem_wena_i;
  assign b0.mem_waddr_i    = b1.mem_waddr_i;
  assign b0.mem_result_i   = b1.mem_result_i;
  assign b0.wb_wena_i      = b1.wb_wena_i;
  assign b0.wb_waddr_i     = b1.wb_waddr_i;
  assign b0.wb_data_i      = b1.wb_data_i;
  assign b0.branch_taken_i = b1.branch_taken_i;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t q1[$];
  exp_t q0[$];
  mstate_t st1, st0;
  stim_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model -------------------------------------------------------
  function automatic bit hit(bit en, bit [4:0] a, bit wen, bit [4:0] wa);
    return en && (a != 0) && wen && (wa == a);
  endfunction

  // Returns 0 = register file, 1 = EX, 2 = MEM, 3 = WB.
  function automatic int src(int mode, bit en, bit [4:0] a, stim_t s);
    if (mode == 1) begin
      if (hit(en, a, s.exw, s.exa) && !s.exld) return 1;
      if (hit(en, a, s.memw, s.mema))          return 2;
      if (hit(en, a, s.wbw, s.wba))            return 3;
      return 0;
    end
    if (hit(en, a, s.wbw, s.wba)) return 3;
    return 0;
  endfunction

  function automatic bit [31:0] pick(int k, bit [31:0] rf, stim_t s);
    case (k)
      1: return s.exr;
      2: return s.memr;
      3: return s.wbd;
      default: return rf;
    endcase
  endfunction

  function automatic bit stall_of(int mode, stim_t s);
    bit exm, memm;
    exm  = hit(s.rsen, s.rs, s.exw, s.exa) || hit(s.rten, s.rt, s.exw, s.exa);
    memm = hit(s.rsen, s.rs, s.memw, s.mema) || hit(s.rten, s.rt, s.memw, s.mema);
    if (mode == 1) return s.valid && s.exld && exm;
    return s.valid && (exm || memm);
  endfunction

  function automatic exp_t model_out(stim_t s, int mode, mstate_t st);
    exp_t e;
    e.rs    = pick(src(mode, s.rsen, s.rs, s), s.rfrs, s);
    e.rt    = pick(src(mode, s.rten, s.rt, s), s.rfrt, s);
    e.stall = stall_of(mode, s);
    e.flush = s.valid && s.br && !e.stall;
    e.err   = st.err;
    e.sc    = st.sc;
    e.fc    = st.fc;
    e.flc   = st.flc;
    return e;
  endfunction

  function automatic mstate_t model_next(stim_t s, int mode, int max_stall, mstate_t st);
    mstate_t n;
    bit stl, fl;
    int nf;
    n   = st;
    stl = stall_of(mode, s);
    fl  = s.valid && s.br && !stl;
    if (stl) begin
      n.run = (st.run + 1 > max_stall) ? max_stall : st.run + 1;
      if (n.run >= max_stall) n.err = 1'b1;
    end else begin
      n.run = 0;
    end
`ifdef HAZARD_PERF_EN
    nf = 0;
    if (s.valid && !stl) begin
      if (src(mode, s.rsen, s.rs, s) != 0) nf++;
      if (src(mode, s.rten, s.rt, s) != 0) nf++;
    end
    n.sc  = st.sc + (stl ? 32'd1 : 32'd0);
    n.fc  = st.fc + 32'(nf);
    n.flc = st.flc + (fl ? 32'd1 : 32'd0);
`else
    nf = 0;
    n.sc = 32'(nf);
    n.fc = 32'(nf);
    n.flc = 32'(nf);
`endif
    return n;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t n;
    n.run = 0; n.err = 1'b0; n.sc = '0; n.fc = '0; n.flc = '0;
    return n;
  endfunction

  // Stimulus helpers ------------------------------------------------------
  function automatic stim_t idle();
    stim_t s;
    s.valid = 1'b1; s.rsen = 1'b0; s.rten = 1'b0; s.exw = 1'b0; s.exld = 1'b0;
    s.memw = 1'b0; s.wbw = 1'b0; s.br = 1'b0;
    s.rs = '0; s.rt = '0; s.exa = '0; s.mema = '0; s.wba = '0;
    s.rfrs = 32'hC0DE_0001; s.rfrt = 32'hC0DE_0002; s.exr = '0; s.memr = '0; s.wbd = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.valid = ($urandom_range(0, 7) != 0);
    s.rsen  = ($urandom_range(0, 3) != 0);
    s.rten  = ($urandom_range(0, 3) != 0);
    s.exw   = ($urandom_range(0, 4) < 3);
    s.exld  = ($urandom_range(0, 9) < 3);
    s.memw  = ($urandom_range(0, 4) < 3);
    s.wbw   = ($urandom_range(0, 4) < 3);
    s.br    = ($urandom_range(0, 3) == 0);
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.exa   = 5'($urandom_range(0, 3));
    s.mema  = 5'($urandom_range(0, 3));
    s.wba   = 5'($urandom_range(0, 3));
    s.rfrs  = $urandom; s.rfrt = $urandom; s.exr = $urandom;
    s.memr  = $urandom; s.wbd  = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    cur = s;
    b1.id_valid_i = s.valid;   b1.id_rs_addr_i = s.rs;    b1.id_rt_addr_i = s.rt;
    b1.id_rs_rena_i = s.rsen;  b1.id_rt_rena_i = s.rten;
    b1.rf_rs_data_i = s.rfrs;  b1.rf_rt_data_i = s.rfrt;
    b1.ex_wena_i = s.exw;      b1.ex_waddr_i = s.exa;     b1.ex_is_load_i = s.exld;
    b1.ex_result_i = s.exr;    b1.mem_wena_i = s.memw;    b1.mem_waddr_i = s.mema;
    b1.mem_result_i = s.memr;  b1.wb_wena_i = s.wbw;      b1.wb_waddr_i = s.wba;
    b1.wb_data_i = s.wbd;      b1.branch_taken_i = s.br;
  endtask

  // One clock of stimulus: drive, queue the expected response, advance the model.
  task automatic step(input stim_t s);
    @(posedge clk_i);
    #1;
    apply(s);
    q1.push_back(model_out(s, 1, st1));
    q0.push_back(model_out(s, 0, st0));
    st1 = model_next(s, 1, 15, st1);
    st0 = model_next(s, 0, 3, st0);
  endtask

  // Asynchronous reset between edges; registered outputs must clear at once.
  task automatic do_reset();
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    st1 = model_reset();
    st0 = model_reset();
    chk("rst_err1", b1.stall_err_o, 0);   chk("rst_err0", b0.stall_err_o, 0);
    chk("rst_sc1", b1.stall_cycles_o, 0); chk("rst_sc0", b0.stall_cycles_o, 0);
    chk("rst_fc1", b1.fwd_count_o, 0);    chk("rst_fc0", b0.fwd_count_o, 0);
    chk("rst_flc1", b1.flush_count_o, 0); chk("rst_flc0", b0.flush_count_o, 0);
    chk("rst_comb_stall0", b0.stall_o, model_out(cur, 0, st0).stall);
    chk("rst_comb_rs1", b1.rs_data_o, model_out(cur, 1, st1).rs);
    #1;
    rst_i = 1'b1;
  endtask

  // Monitor: compare whatever the DUTs present against the queued expectations.
  always @(negedge clk_i) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("m1_rs", b1.rs_data_o, e.rs);         chk("m1_rt", b1.rt_data_o, e.rt);
      chk("m1_stall", b1.stall_o, e.stall);     chk("m1_flush", b1.flush_o, e.flush);
      chk("m1_err", b1.stall_err_o, e.err);     chk("m1_sc", b1.stall_cycles_o, e.sc);
      chk("m1_fc", b1.fwd_count_o, e.fc);       chk("m1_flc", b1.flush_count_o, e.flc);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("m0_rs", b0.rs_data_o, e.rs);         chk("m0_rt", b0.rt_data_o, e.rt);
      chk("m0_stall", b0.stall_o, e.stall);     chk("m0_flush", b0.flush_o, e.flush);
      chk("m0_err", b0.stall_err_o, e.err);     chk("m0_sc", b0.stall_cycles_o, e.sc);
      chk("m0_fc", b0.fwd_count_o, e.fc);       chk("m0_flc", b0.flush_count_o, e.flc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    apply(idle());
    st1 = model_reset();
    st0 = model_reset();
    #2;
    chk("init_err1", b1.stall_err_o, 0);   chk("init_err0", b0.stall_err_o, 0);
    chk("init_sc1", b1.stall_cycles_o, 0); chk("init_fc1", b1.fwd_count_o, 0);
    chk("init_flc1", b1.flush_count_o, 0);
    #1 rst_i = 1'b1;

    // EX ALU result to r8 forwarded into rs.
    s = idle(); s.rsen = 1; s.rs = 8; s.rfrs = 0; s.exw = 1; s.exa = 8; s.exr = 32'h11;
    step(s);
    // Load-use on r9, then the load data arrives through MEM.
    s = idle(); s.rten = 1; s.rt = 9; s.exw = 1; s.exa = 9; s.exld = 1; s.exr = 32'hDEAD;
    step(s);
    s = idle(); s.rten = 1; s.rt = 9; s.memw = 1; s.mema = 9; s.memr = 32'hAB;
    step(s);
    // Priority EX > MEM > WB, then the same writers aimed at r0.
    s = idle(); s.rsen = 1; s.rs = 3; s.exw = 1; s.exa = 3; s.exr = 1;
    s.memw = 1; s.mema = 3; s.memr = 2; s.wbw = 1; s.wba = 3; s.wbd = 3;
    step(s);
    s.rs = 0; s.exa = 0; s.mema = 0; s.wba = 0;
    step(s);
    // MEM RAW on r4 held, then resolved through WB.
    s = idle(); s.rten = 1; s.rt = 4; s.memw = 1; s.mema = 4; s.memr = 32'h44;
    step(s); step(s);
    s = idle(); s.rten = 1; s.rt = 4; s.wbw = 1; s.wba = 4; s.wbd = 32'h55;
    step(s);
    // Taken branch during a load-use stall, then re-resolved.
    s = idle(); s.br = 1; s.rsen = 1; s.rs = 6; s.exw = 1; s.exa = 6; s.exld = 1;
    step(s);
    s = idle(); s.br = 1; s.rsen = 1; s.rs = 6; s.memw = 1; s.mema = 6; s.memr = 32'h66;
    step(s);
    // Long EX match: trips the short watchdog, stays sticky, then reset mid-stall.
    s = idle(); s.rsen = 1; s.rs = 5; s.exw = 1; s.exa = 5; s.exr = 32'h5;
    for (int i = 0; i < 5; i++) step(s);
    s.rsen = 0;
    step(s); step(s);
    s.rsen = 1;
    step(s); step(s);
    do_reset();
    step(idle());

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      step(rnd());
      if ((i % 500) == 499) do_reset();
    end

    @(posedge clk_i);
    @(posedge clk_i);
    chk("queue_drained", 64'(q1.size() + q0.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
